// File: rtl/key_mode_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_mode_pkg                                                             |
// | Lighting-mode constants and classifier state encoding for key_mode_ctrl. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package key_mode_pkg;

    localparam int unsigned MODE_OFF         = 0;
    localparam int unsigned MODE_BREATH_SLOW = 1;
    localparam int unsigned MODE_BREATH_FAST = 2;
    localparam int unsigned MODE_ON          = 3;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 2'd0;
    localparam state_t c_ST_PRESSED   = 2'd1;
    localparam state_t c_ST_LONG_HELD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debounce                                                             |
// | Two-flop synchroniser and restart-on-glitch debounce of an active-low    |
// | push button; key_level is the debounced pressed level.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debounce #(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level
);

    localparam int                 c_CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYC - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_press;

    // Flops idle high so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_press = ~r_sync2;

    // Any sample agreeing with the current level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_press == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= w_press;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign key_level = r_level;

endmodule
`default_nettype wire

// File: rtl/key_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_mode_ctrl                                                            |
// | Debounced button press classifier (short/long) driving the lighting-mode |
// | register consumed by the breathing-LED stage.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_mode_ctrl
    import key_mode_pkg::*;
#(
    parameter int DB_CYC    = 1_000_000,
    parameter int LONG_CYC  = 50_000_000,
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_n,
    output logic              key_level,
    output logic              key_short,
    output logic              key_long,
    output logic [MODE_W-1:0] mode,
    output logic              led_en
);

    localparam int                  c_HOLD_W    = $clog2(LONG_CYC);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYC - 1);
    localparam logic [MODE_W-1:0]   c_MODE_OFF  = MODE_W'(MODE_OFF);
    localparam logic [MODE_W-1:0]   c_MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic                w_level;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                r_short;
    logic                r_long;
    logic                w_short_nxt;
    logic                w_long_nxt;
    logic [MODE_W-1:0]   r_mode;
    logic [MODE_W-1:0]   w_mode_nxt;
    logic                r_led_en;

    key_debounce #(
        .DB_CYC (DB_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .key_level (w_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_hold   <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_mode   <= c_MODE_OFF;
            r_led_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_mode   <= w_mode_nxt;
            r_led_en <= (w_mode_nxt != c_MODE_OFF);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        w_mode_nxt  = r_mode;

        case (r_state)
            c_ST_IDLE: begin
                if (w_level) begin
                    w_state_nxt = c_ST_PRESSED;
                    w_hold_nxt  = '0;
                end
            end
            c_ST_PRESSED: begin
                // Release is tested first so it wins over the long threshold.
                if (!w_level) begin
                    w_state_nxt = c_ST_IDLE;
                    w_short_nxt = 1'b1;
                end else if (r_hold == c_HOLD_LAST) begin
                    w_state_nxt = c_ST_LONG_HELD;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + c_HOLD_W'(1);
                end
            end
            c_ST_LONG_HELD: begin
                if (!w_level) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_short_nxt) begin
            w_mode_nxt = (r_mode == c_MODE_LAST) ? c_MODE_OFF : r_mode + MODE_W'(1);
        end else if (w_long_nxt) begin
            w_mode_nxt = c_MODE_OFF;
        end
    end

    assign key_level = w_level;
    assign key_short = r_short;
    assign key_long  = r_long;
    assign mode      = r_mode;
    assign led_en    = r_led_en;

endmodule
`default_nettype wire
